// File: rtl/vec_shape_seq.sv
// Vector-list sequencer: walks one shape in the vector ROM and streams translated points.
// Optional saturating translation when VEC_SHAPE_SEQ_CLIP_EN is defined (default: wrap).
module vec_shape_seq #(
    parameter int ADDRESSWIDTH = 16,
    parameter int COORDW       = 8,
    parameter int MAX_LEN      = 64,
    parameter int ROM_LAT      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] base_addr,
    input  logic [COORDW-1:0]       x_off,
    input  logic [COORDW-1:0]       y_off,
    output logic [ADDRESSWIDTH-1:0] rom_addr,
    input  logic [2*COORDW+1:0]     rom_data,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic [COORDW-1:0]       vec_x,
    output logic [COORDW-1:0]       vec_y,
    output logic                    vec_line,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int CNTW = $clog2(MAX_LEN + 1);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // A registered ROM needs one address-hold cycle before each fetch.
    localparam logic [2:0] S_NEXT = (ROM_LAT == 1) ? S_WAIT : S_FETCH;

    logic [2:0]              state;
    logic [ADDRESSWIDTH-1:0] ptr;
    logic [CNTW-1:0]         cnt;
    logic [COORDW-1:0]       xo_q;
    logic [COORDW-1:0]       yo_q;

    logic [COORDW-1:0] rx;
    logic [COORDW-1:0] ry;
    logic              rline;
    logic              rpos;
    logic [COORDW:0]   sum_x;
    logic [COORDW:0]   sum_y;
    logic [COORDW-1:0] tx;
    logic [COORDW-1:0] ty;

    assign rx    = rom_data[2*COORDW+1 -: COORDW];
    assign ry    = rom_data[COORDW+1 -: COORDW];
    assign rline = rom_data[1];
    assign rpos  = rom_data[0];

    assign sum_x = {1'b0, rx} + {1'b0, xo_q};
    assign sum_y = {1'b0, ry} + {1'b0, yo_q};

`ifdef VEC_SHAPE_SEQ_CLIP_EN
    assign tx = sum_x[COORDW] ? '1 : sum_x[COORDW-1:0];
    assign ty = sum_y[COORDW] ? '1 : sum_y[COORDW-1:0];
`else
    assign tx = sum_x[COORDW-1:0];
    assign ty = sum_y[COORDW-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            xo_q     <= '0;
            yo_q     <= '0;
            vec_x    <= '0;
            vec_y    <= '0;
            vec_line <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr   <= base_addr;
                        xo_q  <= x_off;
                        yo_q  <= y_off;
                        cnt   <= '0;
                        err   <= 1'b0;
                        state <= S_NEXT;
                    end
                end
                S_WAIT: state <= S_FETCH;
                S_FETCH: begin
                    if (rline && rpos) begin
                        state <= S_DONE;
                    end else if (cnt == MAX_CNT) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        vec_x    <= tx;
                        vec_y    <= ty;
                        vec_line <= rline;
                        state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (vec_ready) begin
                        ptr   <= ptr + 1'b1;
                        cnt   <= cnt + 1'b1;
                        state <= S_NEXT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr  = ptr;
    assign vec_valid = (state == S_OUT);
    assign busy      = (state == S_WAIT) || (state == S_FETCH) || (state == S_OUT);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_vec_shape_seq.sv
// Self-checking bench for vec_shape_seq: three instances (default, MAX_LEN=4, ROM_LAT=1)
// checked against a point-list reference model built from the ROM contents.
module tb_vec_shape_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic [7:0]  xo = '0;
    logic [7:0]  yo = '0;
    logic        rdy = 1'b0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic [17:0] mem [0:255];

    logic [15:0] ra0, ra1, ra2;
    logic [17:0] rd0, rd1, rd2;
    logic        vv0, vv1, vv2, vl0, vl1, vl2;
    logic [7:0]  vx0, vx1, vx2, vy0, vy1, vy2;
    logic        bz0, bz1, bz2, dn0, dn1, dn2, er0, er1, er2;

    assign rd0 = mem[ra0[7:0]];
    assign rd1 = mem[ra1[7:0]];
    always @(posedge clk) rd2 <= mem[ra2[7:0]];

    vec_shape_seq #(.ADDRESSWIDTH(16), .COORDW(8), .MAX_LEN(64), .ROM_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .base_addr(base),
        .x_off(xo), .y_off(yo), .rom_addr(ra0), .rom_data(rd0), .vec_valid(vv0),
        .vec_ready(rdy), .vec_x(vx0), .vec_y(vy0), .vec_line(vl0), .busy(bz0),
        .done(dn0), .err(er0));

    vec_shape_seq #(.ADDRESSWIDTH(16), .COORDW(8), .MAX_LEN(4), .ROM_LAT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .base_addr(base),
        .x_off(xo), .y_off(yo), .rom_addr(ra1), .rom_data(rd1), .vec_valid(vv1),
        .vec_ready(rdy), .vec_x(vx1), .vec_y(vy1), .vec_line(vl1), .busy(bz1),
        .done(dn1), .err(er1));

    vec_shape_seq #(.ADDRESSWIDTH(16), .COORDW(8), .MAX_LEN(64), .ROM_LAT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .base_addr(base),
        .x_off(xo), .y_off(yo), .rom_addr(ra2), .rom_data(rd2), .vec_valid(vv2),
        .vec_ready(rdy), .vec_x(vx2), .vec_y(vy2), .vec_line(vl2), .busy(bz2),
        .done(dn2), .err(er2));

    // Observed signals of the instance under test
    logic [15:0] ra;
    logic [7:0]  vx, vy;
    logic        vv, vl, bz, dn, er;
    assign ra = (sel == 1) ? ra1 : (sel == 2) ? ra2 : ra0;
    assign vv = (sel == 1) ? vv1 : (sel == 2) ? vv2 : vv0;
    assign vx = (sel == 1) ? vx1 : (sel == 2) ? vx2 : vx0;
    assign vy = (sel == 1) ? vy1 : (sel == 2) ? vy2 : vy0;
    assign vl = (sel == 1) ? vl1 : (sel == 2) ? vl2 : vl0;
    assign bz = (sel == 1) ? bz1 : (sel == 2) ? bz2 : bz0;
    assign dn = (sel == 1) ? dn1 : (sel == 2) ? dn2 : dn0;
    assign er = (sel == 1) ? er1 : (sel == 2) ? er2 : er0;

    // Reference model: expected point list for one shape
    int ex[$];
    int ey[$];
    int el[$];
    bit eerr;
    int rbases[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int add_coord(input int a, input int b);
`ifdef VEC_SHAPE_SEQ_CLIP_EN
        return (a + b > 255) ? 255 : a + b;
`else
        return (a + b) % 256;
`endif
    endfunction

    task automatic build_exp(input int b, input int xo_, input int yo_, input int maxlen);
        int addr;
        int n;
        logic [17:0] w;
        ex.delete(); ey.delete(); el.delete();
        eerr = 0;
        addr = b;
        n = 0;
        forever begin
            w = mem[addr % 256];
            if (w[1] && w[0]) break;
            if (n == maxlen) begin
                eerr = 1;
                break;
            end
            ex.push_back(add_coord(int'(w[17:10]), xo_));
            ey.push_back(add_coord(int'(w[9:2]), yo_));
            el.push_back(int'(w[1]));
            n++;
            addr++;
        end
    endtask

    // mode: 0 ready high, 1 random ready, 2 hold ready low 5 cycles on first point,
    // 3 ready high plus a conflicting start while busy
    task automatic run(input int s, input int b, input int xo_, input int yo_, input int mode,
                       input string tag);
        int lat, nexp, ngot, cyc, first_vv, hold;
        bit got_done, pvv, prdy, pvl;
        logic [7:0] pvx, pvy;
        logic [15:0] pra;
        lat = (s == 2) ? 1 : 0;
        build_exp(b, xo_, yo_, (s == 1) ? 4 : 64);
        nexp = ex.size();
        ngot = 0; first_vv = -1; hold = 0; got_done = 0; pvv = 0; prdy = 0;
        pvx = '0; pvy = '0; pvl = 0; pra = '0;
        @(negedge clk);
        sel = s; base = 16'(b); xo = 8'(xo_); yo = 8'(yo_); start = 1'b1; rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= 400 && !got_done) begin
            case (mode)
                1: rdy = 1'($urandom_range(0, 1));
                2: rdy = (hold >= 5);
                default: rdy = 1'b1;
            endcase
            start = (mode == 3 && cyc == 3);
            if (mode == 3 && cyc == 3) begin
                base = 16'd100; xo = 8'd77; yo = 8'd99;
            end
            #1;
            if (cyc == 1) begin
                chk({tag, "_err_clr"}, 32'(er), 0);
                chk({tag, "_first_vv"}, 32'(vv), 0);
            end
            if (pvv && !prdy) begin
                chk({tag, "_hold_valid"}, 32'(vv), 1);
                chk({tag, "_hold_x"}, 32'(vx), 32'(pvx));
                chk({tag, "_hold_y"}, 32'(vy), 32'(pvy));
                chk({tag, "_hold_line"}, 32'(vl), 32'(pvl));
                chk({tag, "_hold_addr"}, 32'(ra), 32'(pra));
            end
            if (vv) begin
                if (first_vv < 0) first_vv = cyc;
                if (!rdy) hold++;
                if (rdy) begin
                    ngot++;
                    if (ngot <= nexp) begin
                        chk({tag, "_x"}, 32'(vx), 32'(ex[ngot-1]));
                        chk({tag, "_y"}, 32'(vy), 32'(ey[ngot-1]));
                        chk({tag, "_line"}, 32'(vl), 32'(el[ngot-1]));
                    end
                end
            end
            if (dn) begin
                got_done = 1;
                chk({tag, "_done_busy"}, 32'(bz), 0);
                chk({tag, "_done_err"}, 32'(er), 32'(eerr));
                chk({tag, "_npoints"}, 32'(ngot), 32'(nexp));
                if (mode == 0 || mode == 3) begin
                    chk({tag, "_done_cyc"}, 32'(cyc), 32'((lat + 2) * (nexp + 1)));
                    if (nexp > 0) chk({tag, "_vv_latency"}, 32'(first_vv), 32'(lat + 2));
                end
            end else begin
                chk({tag, "_busy"}, 32'(bz), 1);
            end
            pvv = vv; prdy = rdy; pvx = vx; pvy = vy; pvl = vl; pra = ra;
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_done) chk({tag, "_timeout"}, 0, 1);
        // start coinciding with done must be ignored
        start = 1'b1; base = 16'd48;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_start_at_done"}, 32'(bz), 0);
        chk({tag, "_idle_valid"}, 32'(vv), 0);
        chk({tag, "_err_hold"}, 32'(er), 32'(eerr));
    endtask

    initial begin
        int a, len, tmo;
        for (int i = 0; i < 256; i++)
            mem[i] = {8'($urandom), 8'($urandom), 2'($urandom_range(0, 2))};
        mem[48] = {8'd22, 8'd50, 2'b01};
        mem[49] = {8'd46, 8'd46, 2'b10};
        mem[50] = {8'd22, 8'd50, 2'b11};
        mem[60] = {8'd250, 8'd3, 2'b10};
        mem[61] = {8'd0, 8'd0, 2'b11};
        mem[86] = {8'd1, 8'd2, 2'b11};
        mem[100] = {8'd9, 8'd9, 2'b11};
        a = 128;
        while (a < 240) begin
            len = $urandom_range(1, 8);
            rbases.push_back(a);
            mem[a + len] = {8'($urandom), 8'($urandom), 2'b11};
            a = a + len + 1;
        end

        #12;
        chk("rst_valid", 32'(vv0), 0);
        chk("rst_busy", 32'(bz0), 0);
        chk("rst_done", 32'(dn0), 0);
        chk("rst_err", 32'(er0), 0);
        chk("rst_addr", 32'(ra0), 0);
        chk("rst_x", 32'(vx0), 0);
        chk("rst_y", 32'(vy0), 0);
        chk("rst_line", 32'(vl0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 48, 0, 0, 0, "basic");
        run(0, 48, 10, 5, 0, "xlate");
        run(0, 60, 10, 0, 0, "edge");
        run(0, 48, 3, 7, 2, "backpr");
        run(1, 80, 0, 0, 0, "maxlen");
        run(1, 100, 0, 0, 0, "errclr");
        run(0, 48, 0, 0, 3, "busyign");
        run(0, 100, 0, 0, 0, "term");
        run(2, 48, 0, 0, 0, "lat1");
        run(1, 48, 0, 0, 0, "ml_short");
        foreach (rbases[k])
            run(int'($urandom_range(0, 2)), rbases[k], int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), 1, "rand");

        // Reset while a point is pending
        @(negedge clk);
        sel = 0; base = 16'd48; xo = '0; yo = '0; rdy = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tmo = 0;
        while (!vv && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        chk("rst_mid_reach_out", 32'(vv), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(vv), 0);
        chk("rst_mid_busy", 32'(bz), 0);
        chk("rst_mid_done", 32'(dn), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(vv), 0);
            chk("post_rst_busy", 32'(bz), 0);
            chk("post_rst_done", 32'(dn), 0);
        end
        run(0, 48, 1, 2, 0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_shape_seq.md
Name: vec_shape_seq

Overview:
- Parametrised vector-list sequencer that walks one shape stored in a vector ROM.
- Starts at a given base address and fetches packed entries {x, y, line, pos}.
- Applies a per-shape X/Y translation and streams the translated points to the line-drawing engine over a valid/ready handshake.
- Stops at the end-of-shape marker (line=1, pos=1), or aborts after MAX_LEN entries. Sits between the game/cursor logic and the XY DAC drawing engine.

Parameters:
- ADDRESSWIDTH, 16, ROM address width.
- COORDW, 8, width of each coordinate field; ROM word is 2*COORDW+2 bits.
- MAX_LEN, 64, maximum entries fetched per shape before abort (terminator excluded).
- ROM_LAT, 0, ROM read latency in cycles; legal values 0 (combinational) or 1 (registered).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to draw a shape; ignored while busy=1.
- base_addr  in  ADDRESSWIDTH  first ROM address of the shape; sampled on accepted start.
- x_off  in  COORDW  X translation; sampled on accepted start.
- y_off  in  COORDW  Y translation; sampled on accepted start.
- rom_addr  out  ADDRESSWIDTH  ROM address.
- rom_data  in  2*COORDW+2  ROM word {x, y, line, pos}, x in MSBs, pos in bit 0.
- vec_valid  out  1  output point valid.
- vec_ready  in  1  drawing engine accepts point.
- vec_x  out  COORDW  translated X.
- vec_y  out  COORDW  translated Y.
- vec_line  out  1  1 = draw line from previous point; 0 = move (beam off).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of shape.
- err  out  1  with done: shape aborted at MAX_LEN; holds until next accepted start.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rom_addr=0, vec_valid=0, vec_x=0, vec_y=0, vec_line=0, busy=0, done=0, err=0; pointer and entry count cleared.
- Reset mid-shape aborts immediately. No done pulse is produced, and no vec_valid is produced after release.
- States:
  - IDLE
    - start=1 → latch base_addr into pointer, latch offsets, count=0, err=0, busy=1.
    - Go to WAIT if ROM_LAT=1, else to FETCH.
  - WAIT: rom_addr=pointer held for one cycle → FETCH.
  - FETCH: rom_addr=pointer; rom_data is sampled at this cycle's edge.
    - line=1 & pos=1 → DONE; the terminator is not emitted.
    - count==MAX_LEN → DONE with err=1.
    - Otherwise register vec_x=x+x_off, vec_y=y+y_off, vec_line=line → OUT.
  - OUT: vec_valid=1, with vec_x/vec_y/vec_line stable until handshake.
    - On vec_valid & vec_ready: pointer+1, count+1, vec_valid=0 next cycle → WAIT/FETCH per ROM_LAT.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- The pos bit alone (line=0, pos=1) marks a new sub-path start. It is emitted as a move (vec_line=0), and any entry with line=0 is a move.
- Latency (ROM_LAT=0): start at cycle N → vec_valid at N+2.
  - With vec_ready tied high, one point every 2 cycles.
  - ROM_LAT=1 adds 1 cycle per entry.
- Arithmetic: the sum is computed at COORDW+1 bits. Default behaviour is wrap (modulo 2^COORDW); see the optional feature.
- Pointer wraps modulo 2^ADDRESSWIDTH.
- start while busy is ignored; offsets and base are not reloaded.
- start in the same cycle as done (DONE state) is ignored; it is accepted from IDLE only.
- vec_ready high while vec_valid=0 has no effect.
- Terminator at base_addr: busy for the FETCH cycle, then done with no vectors, err=0.

Optional Feature:
- Macro VEC_SHAPE_SEQ_CLIP_EN.
- Defined: translated coordinates saturate to 2^COORDW-1 on carry-out, so shapes pinned at the screen edge are not folded back.
- Undefined: coordinates wrap modulo 2^COORDW.

Test Plan:
- Three-entry shape, default params, ROM_LAT=0, x_off=y_off=0, vec_ready=1.
  - Stimulus: ROM at base 48 is {22,50,0,1}, {46,46,1,0}, {22,50,1,1}.
  - Response: two points, (22,50,line0) then (46,46,line1); done at cycle start+6; err=0.
- Translation: same shape with x_off=10, y_off=5 → (32,55) and (56,51).
  - Entry x=250 with x_off=10: vec_x=4 without the macro, 255 with VEC_SHAPE_SEQ_CLIP_EN.
- Backpressure: hold vec_ready=0 for 5 cycles on the first point.
  - vec_valid and data stay stable for all 5 cycles; no pointer advance; the sequence completes normally.
- MAX_LEN=4 with a shape of 6 non-terminator entries → exactly 4 points emitted, then done=1 with err=1.
  - A following start clears err.
- start while busy=1 with a different base_addr is ignored; the original shape completes.
  - Terminator at base_addr → done 2 cycles after start, zero vec_valid.
- Assert rst_n=0 while in OUT → vec_valid, busy, and done go to 0 immediately.
  - After release, no output until a new start.
- ROM_LAT=1 with a registered ROM model → the same point values as the first scenario, with one point every 3 cycles.
